// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default PC behaviour and the prefetch queue entry layout.
package fetch_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT  = 32;
  localparam int unsigned INSTR_WIDTH_DEFAULT = 32;
  localparam int unsigned PC_STEP_DEFAULT     = 4;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

  // Queue entry at default widths; wider/narrower builds use entryWidth()
  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0]  pc;
    logic [INSTR_WIDTH_DEFAULT-1:0] instr;
  } fetchEntry_t;

  function automatic int unsigned entryWidth(input int unsigned addrWidth,
                                             input int unsigned instrWidth);
    return addrWidth + instrWidth;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous power-of-two FIFO with flush and show-ahead head output.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full && !flush;
  assign doPop  = pop && !empty && !flush;
  assign rdData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, iCache request, prefetch queue and redirect handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int unsigned            INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned            QUEUE_DEPTH = 4,
  parameter int unsigned            PC_STEP     = PC_STEP_DEFAULT,
  localparam int unsigned           CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  ic_addr,
  output logic                   ic_req,
  input  logic [INSTR_WIDTH-1:0] ic_instr,
  input  logic                   ic_miss,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   dec_valid,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  input  logic                   dec_ready,
  output logic [CNT_W-1:0]       queue_count
);

  localparam int unsigned ENTRY_W    = entryWidth(ADDR_WIDTH, INSTR_WIDTH);
  localparam int unsigned ALIGN_BITS = $clog2(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~ADDR_WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  qFull;
  logic                  qEmpty;
  logic                  push;
  logic                  pop;
  entry_t                wrEntry;
  entry_t                headEntry;
  logic [ENTRY_W-1:0]    headRaw;

  // Full queue never fetches, even if decode drains it this cycle
  assign ic_addr = pc;
  assign ic_req  = !rst && !qFull && !redirect_valid;
  assign push    = ic_req && !ic_miss;
  assign pop     = dec_valid && dec_ready;

  assign wrEntry   = '{pc: pc, instr: ic_instr};
  assign headEntry = entry_t'(headRaw);

  assign dec_valid = !qEmpty;
  assign dec_instr = qEmpty ? '0 : headEntry.instr;
  assign dec_pc    = qEmpty ? '0 : headEntry.pc;

  // Reset beats redirect, redirect beats sequential advance; a miss holds pc
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ALIGN_MASK;
    end else if (push) begin
      pc <= pc + ADDR_WIDTH'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wrData (ENTRY_W'(wrEntry)),
    .rdData (headRaw),
    .count  (queue_count),
    .full   (qFull),
    .empty  (qEmpty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hit stream, back-pressure, miss, redirect, wrap, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic [31:0] ic_instr;
  logic        ic_miss;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  queue_count;

  int nTests = 0;
  int nFail  = 0;

  localparam logic [31:0] SALT = 32'hDEAD_0000;

  always #5 clk = ~clk;

  // iCache model: instruction word is a fixed function of its address
  assign ic_instr = ic_addr ^ SALT;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ic_addr        (ic_addr),
    .ic_req         (ic_req),
    .ic_instr       (ic_instr),
    .ic_miss        (ic_miss),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .queue_count    (queue_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkHead(input string tag, input logic [31:0] pcExp, input logic [2:0] cntExp);
    #1;
    chk({tag, ".valid"}, 64'(dec_valid), 64'd1);
    chk({tag, ".pc"}, 64'(dec_pc), 64'(pcExp));
    chk({tag, ".instr"}, 64'(dec_instr), 64'(pcExp ^ SALT));
    chk({tag, ".count"}, 64'(queue_count), 64'(cntExp));
  endtask

  task automatic chkEmpty(input string tag, input logic [31:0] addrExp);
    #1;
    chk({tag, ".count"}, 64'(queue_count), 64'd0);
    chk({tag, ".valid"}, 64'(dec_valid), 64'd0);
    chk({tag, ".pc0"}, 64'(dec_pc), 64'd0);
    chk({tag, ".instr0"}, 64'(dec_instr), 64'd0);
    chk({tag, ".addr"}, 64'(ic_addr), 64'(addrExp));
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ic_miss = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; dec_ready = 1'b1;
    tick(); tick();
    chkEmpty("reset", 32'h0);
    chk("reset.req", 64'(ic_req), 64'd0);

    // Hit stream with decode always ready: one per cycle, count stays 1
    rst = 1'b0;
    #1 chk("stream.req", 64'(ic_req), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chkHead($sformatf("stream%0d", k), 32'(4 * k), 3'd1);
    end

    // Back-pressure: fill to 4, fetch stops at 0x10, then drain in order
    doReset();
    dec_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chkHead($sformatf("fill%0d", k), 32'h0, 3'(k + 1));
    end
    chk("full.req", 64'(ic_req), 64'd0);
    chk("full.addr", 64'(ic_addr), 64'h10);
    tick();
    chkHead("fullHold", 32'h0, 3'd4);
    chk("fullHold.addr", 64'(ic_addr), 64'h10);
    dec_ready = 1'b1;
    tick();
    chkHead("drain0", 32'h4, 3'd3);
    chk("drain0.req", 64'(ic_req), 64'd1);
    tick(); chkHead("drain1", 32'h8, 3'd3);
    tick(); chkHead("drain2", 32'hC, 3'd3);
    tick(); chkHead("drain3", 32'h10, 3'd3);

    // Three-cycle miss at 0x8: no pushes, no duplicate afterwards
    doReset();
    tick(); chkHead("preMiss0", 32'h0, 3'd1);
    tick(); chkHead("preMiss1", 32'h4, 3'd1);
    ic_miss = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chkEmpty($sformatf("miss%0d", k), 32'h8);
      chk($sformatf("miss%0d.req", k), 64'(ic_req), 64'd1);
    end
    ic_miss = 1'b0;
    tick(); chkHead("postMiss0", 32'h8, 3'd1);
    tick(); chkHead("postMiss1", 32'hC, 3'd1);

    // Redirect with three queued entries and a pending pop
    doReset();
    dec_ready = 1'b0;
    tick(); tick(); tick();
    chkHead("preRedir", 32'h0, 3'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; dec_ready = 1'b1;
    #1 chk("redir.req", 64'(ic_req), 64'd0);
    tick();
    redirect_valid = 1'b0;
    chkEmpty("redir", 32'h100);
    tick(); chkHead("redirHit", 32'h100, 3'd1);

    // Address wrap from the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chkEmpty("wrapRedir", 32'hFFFF_FFFC);
    tick();
    chkHead("wrapTop", 32'hFFFF_FFFC, 3'd1);
    chk("wrap.addr", 64'(ic_addr), 64'h0);
    tick(); chkHead("wrapZero", 32'h0, 3'd1);

    // Reset while full and during a miss
    dec_ready = 1'b0;
    tick(); tick(); tick();
    chkHead("preRst", 32'h0, 3'd4);
    rst = 1'b1; ic_miss = 1'b1;
    tick();
    chkEmpty("rstFull", 32'h0);
    chk("rstFull.req", 64'(ic_req), 64'd0);
    tick();
    chkEmpty("rstHold", 32'h0);
    chk("rstHold.req", 64'(ic_req), 64'd0);
    rst = 1'b0; ic_miss = 1'b0;
    #1 chk("rstRelease.req", 64'(ic_req), 64'd1);
    tick(); chkHead("rstResume", 32'h0, 3'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
